// File: rtl/vram_pkg.sv
// Shared constants and FSM state encoding for the VRAM arbiter.
package vram_pkg;
  localparam int COLS       = 80;
  localparam int ROWS       = 30;
  localparam int VRAM_DEPTH = 2400;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    DISP,
    DISP_CAP,
    HOST,
    HOST_CAP
  } state_t;
endpackage

// File: rtl/vram_addr_gen.sv
// Text-mode character address: row*80 + col, built from shifts and adds.
import vram_pkg::*;

module vram_addr_gen (
  input  logic [4:0]        row,
  input  logic [6:0]        col,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] row_w;
  logic [ADDR_W-1:0] col_w;

  assign row_w = {{(ADDR_W-5){1'b0}}, row};
  assign col_w = {{(ADDR_W-7){1'b0}}, col};
  assign addr  = (row_w << 6) + (row_w << 4) + col_w;
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches have strict priority over host access.
// Optional macro VRAM_HOST_BLANK_ONLY_EN restricts host service to blanking.
//
// state    | meaning
// IDLE     | no access in flight; display or host may be granted
// DISP     | display read issued to RAM
// DISP_CAP | display read data captured, disp_valid strobe
// HOST     | host access issued (or rejected when out of range)
// HOST_CAP | host read data returned, host_rvalid strobe
import vram_pkg::*;

module vram_arbiter (
  input  logic              reloj,
  input  logic              resetM,
  input  logic              pix_tick,
  input  logic [9:0]        Qh,
  input  logic [9:0]        Qv,
  input  logic              H_ON,
  input  logic              V_ON,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] disp_char,
  output logic              disp_valid
);
  state_t            state, state_nx;
  logic              pend, pend_nx;
  logic              disp_req;
  logic              host_ok;
  logic              host_acc;
  logic [ADDR_W-1:0] disp_addr_c, disp_addr_q;
  logic [ADDR_W-1:0] h_addr_q;
  logic [DATA_W-1:0] h_wdata_q;
  logic              h_we_q;
  logic              h_err_q;

  vram_addr_gen u_addr_gen (
    .row  (Qv[8:4]),
    .col  (Qh[9:3]),
    .addr (disp_addr_c)
  );

  assign disp_req = pix_tick & H_ON & V_ON & (Qh[2:0] == 3'd0);

`ifdef VRAM_HOST_BLANK_ONLY_EN
  assign host_ok = ~(H_ON & V_ON);
`else
  assign host_ok = 1'b1;
`endif

  // Gated by resetM so the grant is low while reset is held.
  assign host_ready = resetM & (state == IDLE) & ~disp_req & ~pend & host_ok;
  assign host_acc   = host_req & host_ready;

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      state       <= IDLE;
      pend        <= 1'b0;
      disp_addr_q <= '0;
      h_addr_q    <= '0;
      h_wdata_q   <= '0;
      h_we_q      <= 1'b0;
      h_err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
      if (disp_req) disp_addr_q <= disp_addr_c;
      if (host_acc) begin
        h_addr_q  <= host_addr;
        h_wdata_q <= host_wdata;
        h_we_q    <= host_we;
        h_err_q   <= (host_addr >= ADDR_W'(VRAM_DEPTH));
      end
    end
  end

  always_comb begin
    state_nx    = state;
    pend_nx     = pend;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    disp_valid  = 1'b0;
    disp_char   = '0;
    host_rvalid = 1'b0;
    host_rdata  = '0;
    host_err    = 1'b0;
    unique case (state)
      IDLE: begin
        if (disp_req || pend) begin
          state_nx = DISP;
          pend_nx  = 1'b0;
        end else if (host_acc) begin
          state_nx = HOST;
        end
      end
      DISP: begin
        ram_en   = 1'b1;
        ram_addr = disp_addr_q;
        state_nx = DISP_CAP;
      end
      DISP_CAP: begin
        disp_valid = 1'b1;
        disp_char  = ram_rdata;
        state_nx   = IDLE;
      end
      HOST: begin
        if (h_err_q) begin
          host_err    = 1'b1;
          host_rvalid = ~h_we_q;
          state_nx    = IDLE;
        end else begin
          ram_en    = 1'b1;
          ram_we    = h_we_q;
          ram_addr  = h_addr_q;
          ram_wdata = h_we_q ? h_wdata_q : '0;
          state_nx  = h_we_q ? IDLE : HOST_CAP;
        end
      end
      HOST_CAP: begin
        host_rvalid = 1'b1;
        host_rdata  = ram_rdata;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // A display request seen while busy is held until the next IDLE.
    if (disp_req && state != IDLE) pend_nx = 1'b1;
  end
endmodule
